// File: rtl/alu_input_ctrl_pkg.sv
// Shared definitions for the operand/opcode entry stage and the downstream ALU FSM.
package alu_in_pkg;

   localparam int ALU_DATA_W = 2;

   typedef enum logic [1:0] {
      S_A    = 2'b00,
      S_B    = 2'b01,
      S_OP   = 2'b10,
      S_DONE = 2'b11
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

endpackage

// File: rtl/alu_input_ctrl_if.sv
// User-entry bus: button and switch bank in, latched operands/opcode and handshake out.
interface alu_input_ctrl_if
   import alu_in_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
) ();

   logic              btn_next_raw;
   logic [DATA_W-1:0] sw_data;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic [1:0]        switch_op;
   logic              confirm_op;
   logic              handshaking;
   logic [1:0]        stage;

   // Master is the board/ALU side; slave is the entry controller itself.
   modport master (
      output btn_next_raw, sw_data,
      input  operand_a, operand_b, switch_op, confirm_op, handshaking, stage
   );

   modport slave (
      input  btn_next_raw, sw_data,
      output operand_a, operand_b, switch_op, confirm_op, handshaking, stage
   );

endinterface

// File: rtl/alu_input_ctrl_btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, optional debouncer, rising-edge press pulse.
// The debouncer is built only when ALU_IN_DEBOUNCE_EN is defined.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   logic sync_meta;
   logic sync_q;
   logic level;
   logic level_q;

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync_q    <= sync_meta;
      end
   end

`ifdef ALU_IN_DEBOUNCE_EN
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [CNT_W-1:0] cnt;

   // Level flips only after the synchronised input disagrees for DEBOUNCE_CYCLES straight cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync_q == level) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         level <= ~level;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign level = sync_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_q <= level;
         press   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/alu_input_ctrl.sv
// Operand/opcode entry stage: one button steps A -> B -> OP -> DONE, latching the switch bank.
// Button debouncing is included when ALU_IN_DEBOUNCE_EN is defined.
module alu_input_ctrl
   import alu_in_pkg::*;
#(
   parameter int DATA_W          = ALU_DATA_W,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic             clk,
   input logic             reset,
   alu_input_ctrl_if.slave bus
);

   logic              press;
   logic [DATA_W-1:0] sw_meta;
   logic [DATA_W-1:0] sw_sync;
   logic [1:0]        op_bits;
   state_t            state;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.btn_next_raw),
      .press (press)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= bus.sw_data;
         sw_sync <= sw_meta;
      end
   end

   if (DATA_W >= 2) begin : g_op_wide
      assign op_bits = sw_sync[1:0];
   end else begin : g_op_narrow
      assign op_bits = {1'b0, sw_sync[0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_A;
         bus.operand_a   <= '0;
         bus.operand_b   <= '0;
         bus.switch_op   <= 2'b00;
         bus.confirm_op  <= 1'b0;
         bus.handshaking <= 1'b0;
      end else begin
         // NOTE: confirm_op defaults low every cycle so it can only ever be a one-cycle pulse.
         bus.confirm_op <= 1'b0;
         if (press) begin
            unique case (state)
               S_A: begin
                  bus.operand_a <= sw_sync;
                  state         <= S_B;
               end
               S_B: begin
                  bus.operand_b   <= sw_sync;
                  bus.handshaking <= 1'b1;
                  state           <= S_OP;
               end
               S_OP: begin
                  bus.switch_op  <= op_bits;
                  bus.confirm_op <= 1'b1;
                  state          <= S_DONE;
               end
               S_DONE: begin
                  bus.handshaking <= 1'b0;
                  state           <= S_A;
               end
               default: state <= S_A;
            endcase
         end
      end
   end

   assign bus.stage = state;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed bench for alu_input_ctrl with DEBOUNCE_CYCLES = 4; adapts to ALU_IN_DEBOUNCE_EN.
module tb_alu_input_ctrl;
   import alu_in_pkg::*;

   localparam int DC   = 4;
   localparam int HOLD = 12;
`ifdef ALU_IN_DEBOUNCE_EN
   localparam int LAT = 2 + DC + 1;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   int         confirm_count = 0;
   logic [1:0] cap_op, cap_res;

   alu_input_ctrl_if #(.DATA_W(2)) bus ();

   alu_input_ctrl #(
      .DATA_W          (2),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] alu_model(logic [1:0] a, logic [1:0] b, logic [1:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_OR:   return a | b;
         default: return a & b;
      endcase
   endfunction

   // Downstream ALU stand-in: samples opcode and operands whenever confirm_op is seen.
   always @(negedge clk) begin
      if (!reset && bus.confirm_op) begin
         confirm_count++;
         cap_op  = bus.switch_op;
         cap_res = alu_model(bus.operand_a, bus.operand_b, bus.switch_op);
      end
   end

   task automatic press_btn();
      @(posedge clk); #1 bus.btn_next_raw = 1'b1;
      repeat (HOLD) @(posedge clk);
      #1 bus.btn_next_raw = 1'b0;
      repeat (HOLD) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.btn_next_raw = 1'b0;
      bus.sw_data = 2'b00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if (bus.stage !== 2'b00) $display("FAIL reset_stage: got %b want 00", bus.stage); else n_pass++;
      n_checks++; if (bus.operand_a !== 2'b00) $display("FAIL reset_operand_a: got %b want 00", bus.operand_a); else n_pass++;
      n_checks++; if (bus.operand_b !== 2'b00) $display("FAIL reset_operand_b: got %b want 00", bus.operand_b); else n_pass++;
      n_checks++; if (bus.switch_op !== 2'b00) $display("FAIL reset_switch_op: got %b want 00", bus.switch_op); else n_pass++;
      n_checks++; if (bus.handshaking !== 1'b0) $display("FAIL reset_handshaking: got %b want 0", bus.handshaking); else n_pass++;
      n_checks++; if (confirm_count !== 0) $display("FAIL reset_no_confirm: got %0d pulses want 0", confirm_count); else n_pass++;
   endtask

   task automatic test_basic_sequence();
      int c0;
      c0 = confirm_count;
      bus.sw_data = 2'b11; press_btn();
      n_checks++; if (bus.operand_a !== 2'b11) $display("FAIL basic_operand_a: got %b want 11", bus.operand_a); else n_pass++;
      n_checks++; if (bus.stage !== 2'b01) $display("FAIL basic_stage_b: got %b want 01", bus.stage); else n_pass++;
      bus.sw_data = 2'b11; press_btn();
      n_checks++; if (bus.operand_b !== 2'b11) $display("FAIL basic_operand_b: got %b want 11", bus.operand_b); else n_pass++;
      n_checks++; if (bus.handshaking !== 1'b1) $display("FAIL basic_handshaking: got %b want 1", bus.handshaking); else n_pass++;
      bus.sw_data = 2'b00; press_btn();
      n_checks++; if (confirm_count - c0 !== 1) $display("FAIL basic_confirm_pulses: got %0d want 1", confirm_count - c0); else n_pass++;
      n_checks++; if (cap_op !== OP_ADD) $display("FAIL basic_op_at_confirm: got %b want 00", cap_op); else n_pass++;
      n_checks++; if (cap_res !== 2'b10) $display("FAIL basic_alu_result: got %b want 10", cap_res); else n_pass++;
      n_checks++; if (bus.stage !== 2'b11) $display("FAIL basic_stage_done: got %b want 11", bus.stage); else n_pass++;
      press_btn();
      n_checks++; if (bus.stage !== 2'b00) $display("FAIL basic_back_to_a: got %b want 00", bus.stage); else n_pass++;
      n_checks++; if (bus.handshaking !== 1'b0) $display("FAIL basic_hs_drop: got %b want 0", bus.handshaking); else n_pass++;
      n_checks++; if (bus.operand_a !== 2'b11) $display("FAIL basic_a_kept: got %b want 11", bus.operand_a); else n_pass++;
   endtask

   // Press reaches the FSM LAT edges after the raw edge; the stage moves on the following edge.
   task automatic test_latency();
      bus.sw_data = 2'b01;
      repeat (4) @(posedge clk);
      #1 bus.btn_next_raw = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      n_checks++; if (bus.stage !== 2'b00) $display("FAIL latency_early: got stage %b want 00", bus.stage); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (bus.stage !== 2'b01) $display("FAIL latency_step: got stage %b want 01", bus.stage); else n_pass++;
      n_checks++; if (bus.operand_a !== 2'b01) $display("FAIL latency_operand_a: got %b want 01", bus.operand_a); else n_pass++;
      bus.btn_next_raw = 1'b0;
      repeat (HOLD) @(posedge clk);
      n_checks++; if (bus.stage !== 2'b01) $display("FAIL latency_single_step: got stage %b want 01", bus.stage); else n_pass++;
   endtask

`ifdef ALU_IN_DEBOUNCE_EN
   task automatic test_glitch();
      bus.sw_data = 2'b10;
      @(posedge clk); #1 bus.btn_next_raw = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.btn_next_raw = 1'b0;
      repeat (HOLD) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.stage !== 2'b00) $display("FAIL glitch_no_press: got stage %b want 00", bus.stage); else n_pass++;
   endtask

   task automatic test_bouncy();
      bus.sw_data = 2'b10;
      @(posedge clk); #1 bus.btn_next_raw = 1'b1;
      @(posedge clk); #1 bus.btn_next_raw = 1'b0;
      @(posedge clk); #1 bus.btn_next_raw = 1'b1;
      repeat (10) @(posedge clk);
      #1 bus.btn_next_raw = 1'b0;
      repeat (HOLD) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.stage !== 2'b01) $display("FAIL bouncy_one_step: got stage %b want 01", bus.stage); else n_pass++;
      n_checks++; if (bus.operand_a !== 2'b10) $display("FAIL bouncy_operand_a: got %b want 10", bus.operand_a); else n_pass++;
   endtask
`endif

   task automatic test_sweep();
      logic [1:0] a_v [3] = '{2'b11, 2'b01, 2'b11};
      logic [1:0] b_v [3] = '{2'b01, 2'b10, 2'b10};
      logic [1:0] o_v [3] = '{OP_SUB, OP_OR, OP_AND};
      logic [1:0] r_v [3] = '{2'b10, 2'b11, 2'b10};
      for (int i = 0; i < 3; i++) begin
         int c0;
         c0 = confirm_count;
         bus.sw_data = a_v[i]; press_btn();
         bus.sw_data = b_v[i]; press_btn();
         bus.sw_data = o_v[i]; press_btn();
         n_checks++; if (bus.switch_op !== o_v[i]) $display("FAIL sweep%0d_switch_op: got %b want %b", i, bus.switch_op, o_v[i]); else n_pass++;
         n_checks++; if (cap_op !== o_v[i]) $display("FAIL sweep%0d_op_at_confirm: got %b want %b", i, cap_op, o_v[i]); else n_pass++;
         n_checks++; if (confirm_count - c0 !== 1) $display("FAIL sweep%0d_confirm_pulses: got %0d want 1", i, confirm_count - c0); else n_pass++;
         n_checks++; if (cap_res !== r_v[i]) $display("FAIL sweep%0d_alu_result: got %b want %b", i, cap_res, r_v[i]); else n_pass++;
         press_btn();
         n_checks++; if (bus.stage !== 2'b00) $display("FAIL sweep%0d_stage_a: got %b want 00", i, bus.stage); else n_pass++;
         n_checks++; if (bus.handshaking !== 1'b0) $display("FAIL sweep%0d_hs_drop: got %b want 0", i, bus.handshaking); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_entry();
      int c0;
      bus.sw_data = 2'b11; press_btn();
      bus.sw_data = 2'b01; press_btn();
      n_checks++; if (bus.stage !== 2'b10) $display("FAIL mid_reach_op: got stage %b want 10", bus.stage); else n_pass++;
      c0 = confirm_count;
      @(negedge clk); #2 reset = 1'b1;
      #1;
      n_checks++; if (bus.stage !== 2'b00) $display("FAIL mid_async_stage: got %b want 00", bus.stage); else n_pass++;
      n_checks++; if (bus.operand_a !== 2'b00) $display("FAIL mid_async_operand_a: got %b want 00", bus.operand_a); else n_pass++;
      n_checks++; if (bus.operand_b !== 2'b00) $display("FAIL mid_async_operand_b: got %b want 00", bus.operand_b); else n_pass++;
      n_checks++; if (bus.handshaking !== 1'b0) $display("FAIL mid_async_hs: got %b want 0", bus.handshaking); else n_pass++;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (HOLD) @(negedge clk);
      n_checks++; if (confirm_count !== c0) $display("FAIL mid_no_confirm: got %0d pulses want %0d", confirm_count, c0); else n_pass++;
      n_checks++; if (bus.stage !== 2'b00) $display("FAIL mid_stays_a: got %b want 00", bus.stage); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_sequence();
      test_latency();
      do_reset();
`ifdef ALU_IN_DEBOUNCE_EN
      test_glitch();
      test_bouncy();
      do_reset();
`endif
      test_sweep();
      test_reset_mid_entry();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_input_ctrl.md
Name: alu_input_ctrl

Overview:
Front-end operand/opcode entry stage that feeds the FSM_ALU block directly upstream.
- Conditions one raw pushbutton: synchronises, debounces and edge-detects it.
- Walks the user through three entry steps: operand A, operand B, opcode, all taken from a shared switch bank.
- Drives operand_a, operand_b, switch_op, handshaking and a single-cycle confirm_op to the ALU FSM.

Parameters:
DATA_W, 2, width of operands and opcode field (switch bank width)
DEBOUNCE_CYCLES, 500000, consecutive cycles the synchronised button must hold a new level before it is accepted (≈10 ms @ 50 MHz); benches override it to 4

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_next_raw  input  1  raw, bouncy, asynchronous pushbutton (1 = pressed)
sw_data  input  DATA_W  raw switch bank; sampled through a 2-flop synchroniser
operand_a  output  DATA_W  latched operand A to ALU FSM
operand_b  output  DATA_W  latched operand B to ALU FSM
switch_op  output  2  latched opcode: 00 ADD, 01 SUB, 10 OR, 11 AND
confirm_op  output  1  one-cycle pulse telling the ALU FSM to execute
handshaking  output  1  high while the operands are valid and held for the ALU
stage  output  2  current entry step for LEDs: 00 A, 01 B, 10 OP, 11 DONE

Behaviour:
- Reset (async assert, sync release): state=S_A; operand_a, operand_b, switch_op = 0; confirm_op=0; handshaking=0; stage=00; debounce counter=0; debounced level=0. Reset mid-entry discards any partial entry.
- Button path: 2-flop synchroniser -> debouncer -> rising-edge detector.
  - The debouncer keeps a stable level and a counter. The counter increments while the synchronised level differs from the stable level.
  - The counter clears whenever the two levels are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the stable level toggles and the counter clears.
  - press = stable level rising edge; a one-cycle pulse, registered.
  - Latency from a clean raw edge to press: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - A held button yields exactly one press. A glitch shorter than DEBOUNCE_CYCLES yields none.
- sw_data is passed through its own 2-flop synchroniser (sw_sync). It is not debounced.
- FSM: on each press, exactly one transition happens, with the listed side effects registered on the same edge.
  - S_A --press--> S_B: operand_a <= sw_sync.
  - S_B --press--> S_OP: operand_b <= sw_sync; handshaking <= 1.
  - S_OP --press--> S_DONE: switch_op <= sw_sync[1:0]; confirm_op <= 1 for exactly one cycle. switch_op and confirm_op become visible in the same cycle, so the opcode is valid when the ALU samples confirm_op.
  - S_DONE --press--> S_A: handshaking <= 0. Operands and switch_op keep their old values until overwritten.
  - No press: hold state and all outputs; confirm_op = 0.
- Back-to-back presses are impossible by construction (a release must be debounced first), so no press is ever lost or double-counted.
- stage = state encoding, registered.
- When DATA_W < 2, switch_op zero-extends sw_sync. When DATA_W > 2, switch_op uses the two LSBs.

Optional Feature:
ALU_IN_DEBOUNCE_EN
- Defined: debouncer is present, as described above.
- Undefined: debouncer removed; press = rising edge of the synchronised button directly, with latency 3 cycles. DEBOUNCE_CYCLES is ignored. Intended for simulation and clean-signal sources.

Decomposition:
- Package alu_in_pkg:
  - DATA_W default constant.
  - State enum (S_A=2'b00, S_B=2'b01, S_OP=2'b10, S_DONE=2'b11).
  - Opcode constants OP_ADD/OP_SUB/OP_OR/OP_AND.
  - Shared with the ALU FSM.
- Sub-module btn_conditioner (synchroniser + debouncer + edge detect, parameter DEBOUNCE_CYCLES, output press). It is instantiated once here and is reusable for other buttons.

Test Plan:
- Reset held for 2 cycles, then released -> all outputs 0, stage=00, confirm_op never pulses.
- DEBOUNCE_CYCLES=4. Run the sequence below and check the results:
  - sw_data=11, clean press -> operand_a=11, stage=01.
  - sw_data=11, press -> operand_b=11, handshaking=1.
  - sw_data=00, press -> switch_op=00 and confirm_op high for exactly 1 cycle, same cycle.
  - A downstream ALU model yields 10.
- Bouncy press: the raw signal toggles 1/0 every cycle for 3 cycles, then holds 1 for 10 cycles -> exactly one press, one state step. A 3-cycle glitch alone -> no press.
- Full SUB/OR/AND sweep: A=11, B=01, op=01; then A=01, B=10, op=10; then A=11, B=10, op=11 -> switch_op correct each time, one confirm_op per round. A press in S_DONE returns stage to 00 and drops handshaking.
- Assert reset while in S_OP with operand_a=11 and operand_b=01 -> outputs clear immediately (asynchronously), state=S_A, no confirm_op.
- ALU_IN_DEBOUNCE_EN undefined: a clean press -> press pulse 3 cycles after the raw edge, and the state advances one step.
